boot_mem_arbiter: RTL

- Owns the data-memory write port of the RV32I core and shares it between the external loader (the Ext_MemWrite/Ext_WriteData/Ext_DataAdr path) and the CPU.
- Holds the core in reset while the loader fills memory, then releases it after a fixed hold window.
- Sits between the top level and the core/memory: external loader on one side, CPU store port on the other, single memory write port out.

---
 rtl/boot_mem_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/boot_mem_arbiter.sv
// boot_mem_arbiter: shares the data-memory write port between the external loader
// and the RV32I core, and holds the core in reset until loading finishes.
module boot_mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned RESET_HOLD   = 4,
    parameter int unsigned BOOT_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Ext_Req,
    input  logic              Ext_MemWrite,
    input  logic [ADDR_W-1:0] Ext_DataAdr,
    input  logic [DATA_W-1:0] Ext_WriteData,
    input  logic              Ext_Done,
    output logic              Ext_Gnt,
    input  logic              Cpu_MemWrite,
    input  logic [ADDR_W-1:0] Cpu_DataAdr,
    input  logic [DATA_W-1:0] Cpu_WriteData,
    output logic              Mem_MemWrite,
    output logic [ADDR_W-1:0] Mem_DataAdr,
    output logic [DATA_W-1:0] Mem_WriteData,
    output logic              Cpu_Reset,
    output logic [CNT_W-1:0]  Load_Count,
    output logic [1:0]        State
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoad    = 2'd1,
        StRelease = 2'd2,
        StRun     = 2'd3
    } state_e;

    state_e           state_q;
    logic [31:0]      idle_q;
    logic [31:0]      hold_q;
    logic [CNT_W-1:0] load_q;

    // FSM plus idle, hold and loaded-word counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idle_q  <= '0;
            hold_q  <= '0;
            load_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Ext_Req) begin
                        state_q <= StLoad;
                        idle_q  <= '0;
                        load_q  <= '0;
                    end else if ((BOOT_TIMEOUT != 0) && (idle_q == BOOT_TIMEOUT - 1)) begin
                        // No loader showed up: boot whatever is in memory.
                        state_q <= StRelease;
                        idle_q  <= '0;
                    end else begin
                        idle_q <= idle_q + 32'd1;
                    end
                end
                StLoad: begin
                    // The write in the Done cycle still counts.
                    if (Ext_MemWrite && (load_q != '1)) begin
                        load_q <= load_q + 1'b1;
                    end
                    if (Ext_Done) begin
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    if (hold_q == RESET_HOLD - 1) begin
                        state_q <= StRun;
                        hold_q  <= '0;
                    end else begin
                        hold_q <= hold_q + 32'd1;
                    end
                end
                StRun: begin
                    if (Ext_Req) begin
                        state_q <= StLoad;
                        load_q  <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output decode and zero-latency write-port mux from the registered state.
    always_comb begin
        Ext_Gnt       = (state_q == StLoad);
        Cpu_Reset     = (state_q != StRun);
        Load_Count    = load_q;
        State         = state_q;
        Mem_MemWrite  = 1'b0;
        Mem_DataAdr   = '0;
        Mem_WriteData = '0;
        if (state_q == StLoad) begin
            Mem_MemWrite  = Ext_MemWrite;
            Mem_DataAdr   = Ext_DataAdr;
            Mem_WriteData = Ext_WriteData;
        end else if (state_q == StRun) begin
            Mem_MemWrite  = Cpu_MemWrite;
            Mem_DataAdr   = Cpu_DataAdr;
            Mem_WriteData = Cpu_WriteData;
        end
    end

endmodule
